// File: rtl/interlock_pkg.sv
// ----------------------------------------------------------------------------
// interlock_pkg : shared state encodings and register-match helper   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package interlock_pkg;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] SPLIT = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  typedef enum logic [1:0] {
    S_RUN   = RUN,
    S_SPLIT = SPLIT,
    S_FLUSH = FLUSH
  } state_e;

  // Widest register index the helper accepts; callers zero-extend into it.
  localparam int                 MATCH_W  = 32;
  localparam logic [MATCH_W-1:0] REG_ZERO = '0;

  function automatic logic reg_match(input logic [MATCH_W-1:0] a,
                                     input logic [MATCH_W-1:0] b);
    return (a == b) && (a != REG_ZERO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/interlock_unit_hazard_compare.sv
// ----------------------------------------------------------------------------
// hazard_compare : load-use and intra-bundle RAW detection   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_compare
  import interlock_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic             ex_memread1_i,
  input  logic [REG_W-1:0] ex_rd1_i,
  input  logic             ex_memread2_i,
  input  logic [REG_W-1:0] ex_rd2_i,
  input  logic [REG_W-1:0] id_rm1_i,
  input  logic [REG_W-1:0] id_rn1_i,
  input  logic             id_regwrite1_i,
  input  logic [REG_W-1:0] id_rd1_i,
  input  logic             id_valid2_i,
  input  logic [REG_W-1:0] id_rm2_i,
  input  logic [REG_W-1:0] id_rn2_i,
  output logic             lu_slot1_o,
  output logic             lu_slot2_o,
  output logic             raw_intra_o
);

  logic [REG_W-1:0] w_src [4];
  logic [3:0]       w_lu_src;

  assign w_src[0] = id_rm1_i;
  assign w_src[1] = id_rn1_i;
  assign w_src[2] = id_rm2_i;
  assign w_src[3] = id_rn2_i;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_src
    assign w_lu_src[gi] =
        (ex_memread1_i && reg_match(MATCH_W'(ex_rd1_i), MATCH_W'(w_src[gi]))) ||
        (ex_memread2_i && reg_match(MATCH_W'(ex_rd2_i), MATCH_W'(w_src[gi])));
  end

  assign lu_slot1_o  = w_lu_src[0] | w_lu_src[1];
  assign lu_slot2_o  = id_valid2_i & (w_lu_src[2] | w_lu_src[3]);
  assign raw_intra_o = id_valid2_i && id_regwrite1_i &&
                       (reg_match(MATCH_W'(id_rd1_i), MATCH_W'(id_rm2_i)) ||
                        reg_match(MATCH_W'(id_rd1_i), MATCH_W'(id_rn2_i)));

endmodule

`default_nettype wire

// File: rtl/interlock_unit.sv
// ----------------------------------------------------------------------------
// interlock_unit : dual-issue pipeline stall / split / flush controller  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module interlock_unit
  import interlock_pkg::*;
#(
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_memread1,
  input  logic [REG_W-1:0] id_ex_rd1,
  input  logic             id_ex_memread2,
  input  logic [REG_W-1:0] id_ex_rd2,
  input  logic [REG_W-1:0] if_id_rm1,
  input  logic [REG_W-1:0] if_id_rn1,
  input  logic             if_id_regwrite1,
  input  logic [REG_W-1:0] if_id_rd1,
  input  logic             if_id_valid2,
  input  logic [REG_W-1:0] if_id_rm2,
  input  logic [REG_W-1:0] if_id_rn2,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble1,
  output logic             id_ex_bubble2,
  output logic [CNT_W-1:0] stall_count
);

  localparam int              FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] C_FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0] C_FC_ONE  = FC_W'(1);

  state_e           state_q, state_d;
  logic [FC_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q;

  logic w_lu_slot1, w_lu_slot2, w_raw;

  hazard_compare #(.REG_W(REG_W)) u_cmp (
    .ex_memread1_i  (id_ex_memread1),
    .ex_rd1_i       (id_ex_rd1),
    .ex_memread2_i  (id_ex_memread2),
    .ex_rd2_i       (id_ex_rd2),
    .id_rm1_i       (if_id_rm1),
    .id_rn1_i       (if_id_rn1),
    .id_regwrite1_i (if_id_regwrite1),
    .id_rd1_i       (if_id_rd1),
    .id_valid2_i    (if_id_valid2),
    .id_rm2_i       (if_id_rm2),
    .id_rn2_i       (if_id_rn2),
    .lu_slot1_o     (w_lu_slot1),
    .lu_slot2_o     (w_lu_slot2),
    .raw_intra_o    (w_raw)
  );

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble1 = 1'b0;
    id_ex_bubble2 = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_RUN: begin
        if (branch_taken) begin
          if_id_flush   = 1'b1;
          id_ex_bubble1 = 1'b1;
          id_ex_bubble2 = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = C_FC_LOAD;
          end
        end else if (w_lu_slot1 || w_lu_slot2) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_bubble1 = 1'b1;
          id_ex_bubble2 = 1'b1;
        end else if (w_raw) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_bubble2 = 1'b1;
          state_d       = S_SPLIT;
        end
      end

      // Slot 1 already went down the pipe; only slot 2 remains to issue.
      S_SPLIT: begin
        id_ex_bubble1 = 1'b1;
        if (branch_taken) begin
          if_id_flush   = 1'b1;
          id_ex_bubble2 = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = C_FC_LOAD;
          end else begin
            state_d = S_RUN;
          end
        end else if (w_lu_slot2) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_bubble2 = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end

      S_FLUSH: begin
        if_id_flush   = 1'b1;
        id_ex_bubble1 = 1'b1;
        id_ex_bubble2 = 1'b1;
        if (cnt_q <= C_FC_ONE) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - C_FC_ONE;
        end
      end

      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase

    if (reset) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble1 = 1'b1;
      id_ex_bubble2 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_q;

endmodule

`default_nettype wire
